// File: rtl/dma_pkg.sv
// Shared definitions for the DMA response demultiplexer: FSM state
// encoding, channel-select encoding and the bus ERROR response code.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ERR1 = 2'd2
  } dma_state_e;

  // Address-phase owner encoding carried on addr_sel / dp_sel.
  localparam logic CH_A = 1'b1;
  localparam logic CH_B = 1'b0;

  // HRESP value signalling an ERROR response.
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/dma_beat_cnt.sv
// Per-channel successful-beat counter; wraps silently at 2^CNT_W-1.
module dma_beat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: advance by one on each delivered beat.
  always_comb begin
    cnt_d = cnt_q;
    if (inc) cnt_d = cnt_q + CNT_W'(1);
  end

  // Count register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dma_resp_demux.sv
// Steers AHB data-phase read responses to one of two DMA channels based on
// which channel owned the matching address phase.
// Optional feature: define DMA_RESP_DEMUX_ERR_EN to decode the two-cycle
// ERROR response into per-channel err pulses; otherwise HRESP is ignored.
module dma_resp_demux
  import dma_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             addr_valid,
  input  logic             addr_sel,
  input  logic             HREADY,
  input  logic [WIDTH-1:0] HRDATA,
  input  logic             HRESP,
  output logic [WIDTH-1:0] ch_a_rdata,
  output logic [WIDTH-1:0] ch_b_rdata,
  output logic             ch_a_valid,
  output logic             ch_b_valid,
  output logic             ch_a_err,
  output logic             ch_b_err,
  output logic [CNT_W-1:0] ch_a_beats,
  output logic [CNT_W-1:0] ch_b_beats,
  output logic             busy
);

  dma_state_e       state_q, state_d;
  logic             dp_valid_q, dp_valid_d;
  logic             dp_sel_q, dp_sel_d;
  logic [WIDTH-1:0] a_rdata_q, a_rdata_d;
  logic [WIDTH-1:0] b_rdata_q, b_rdata_d;
  logic             a_valid_q, a_valid_d;
  logic             b_valid_q, b_valid_d;
  logic             beat_done;  // data phase completes this cycle
  logic             beat_err;   // ...and it completes with ERROR

  // Pipeline the address phase, run the response FSM and steer read data.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    dp_valid_d = dp_valid_q;
    dp_sel_d   = dp_sel_q;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    a_valid_d  = 1'b0;
    b_valid_d  = 1'b0;
    beat_done  = 1'b0;
    beat_err   = 1'b0;

    // The bus only advances the address phase on HREADY.
    if (HREADY) begin
      dp_valid_d = addr_valid;
      dp_sel_d   = addr_sel;
    end

    unique case (state_q)
      IDLE: begin
        if (HREADY && addr_valid) state_d = DATA;
      end
      DATA: begin
        if (HREADY) begin
          beat_done = 1'b1;
`ifdef DMA_RESP_DEMUX_ERR_EN
          beat_err  = (HRESP == HRESP_ERROR);
`endif
          state_d   = addr_valid ? DATA : IDLE;
        end
`ifdef DMA_RESP_DEMUX_ERR_EN
        // First cycle of the two-cycle ERROR response.
        else if (HRESP == HRESP_ERROR) begin
          state_d = ERR1;
        end
`endif
      end
      ERR1: begin
`ifdef DMA_RESP_DEMUX_ERR_EN
        if (HREADY) begin
          beat_done = 1'b1;
          beat_err  = 1'b1;
          state_d   = addr_valid ? DATA : IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    // Successful beat: latch data for the owner and pulse its valid.
    if (beat_done && dp_valid_q && !beat_err) begin
      if (dp_sel_q == CH_A) begin
        a_rdata_d = HRDATA;
        a_valid_d = 1'b1;
      end else begin
        b_rdata_d = HRDATA;
        b_valid_d = 1'b1;
      end
    end
  end

  // State, owner pipeline and response registers.
  // NOTE: the read-data registers are plain flops, not a memory, so they take the reset too.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= IDLE;
      dp_valid_q <= 1'b0;
      dp_sel_q   <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      a_valid_q  <= 1'b0;
      b_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dp_valid_q <= dp_valid_d;
      dp_sel_q   <= dp_sel_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      a_valid_q  <= a_valid_d;
      b_valid_q  <= b_valid_d;
    end
  end

`ifdef DMA_RESP_DEMUX_ERR_EN
  logic a_err_q, a_err_d;
  logic b_err_q, b_err_d;

  // ERROR completion: pulse err for the owner instead of valid.
  always_comb begin
    a_err_d = beat_done && beat_err && dp_valid_q && (dp_sel_q == CH_A);
    b_err_d = beat_done && beat_err && dp_valid_q && (dp_sel_q == CH_B);
  end

  // Error pulse registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_err_q <= 1'b0;
      b_err_q <= 1'b0;
    end else begin
      a_err_q <= a_err_d;
      b_err_q <= b_err_d;
    end
  end

  assign ch_a_err = a_err_q;
  assign ch_b_err = b_err_q;
`else
  // Without error decoding HRESP has no effect.
  logic unused_hresp;
  assign unused_hresp = HRESP;
  assign ch_a_err     = 1'b0;
  assign ch_b_err     = 1'b0;
`endif

  dma_beat_cnt #(.CNT_W(CNT_W)) u_cnt_a (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .inc   (a_valid_d),
    .cnt   (ch_a_beats)
  );

  dma_beat_cnt #(.CNT_W(CNT_W)) u_cnt_b (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .inc   (b_valid_d),
    .cnt   (ch_b_beats)
  );

  assign ch_a_rdata = a_rdata_q;
  assign ch_b_rdata = b_rdata_q;
  assign ch_a_valid = a_valid_q;
  assign ch_b_valid = b_valid_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dma_resp_demux.sv
// Scoreboard bench for dma_resp_demux: stimulus pushes expected pulses,
// a negedge monitor pops and compares whenever the DUT pulses.
module tb_dma_resp_demux;
  import dma_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        addr_valid, addr_sel, HREADY, HRESP;
  logic [31:0] HRDATA;
  logic [31:0] ch_a_rdata, ch_b_rdata;
  logic        ch_a_valid, ch_b_valid, ch_a_err, ch_b_err;
  logic [7:0]  ch_a_beats, ch_b_beats;
  logic        busy;

  dma_resp_demux #(.WIDTH(32), .CNT_W(8)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .addr_valid (addr_valid),
    .addr_sel   (addr_sel),
    .HREADY     (HREADY),
    .HRDATA     (HRDATA),
    .HRESP      (HRESP),
    .ch_a_rdata (ch_a_rdata),
    .ch_b_rdata (ch_b_rdata),
    .ch_a_valid (ch_a_valid),
    .ch_b_valid (ch_b_valid),
    .ch_a_err   (ch_a_err),
    .ch_b_err   (ch_b_err),
    .ch_a_beats (ch_a_beats),
    .ch_b_beats (ch_b_beats),
    .busy       (busy)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  flags;  // {a_valid, b_valid, a_err, b_err}
    logic [31:0] a_rd;
    logic [31:0] b_rd;
    logic [7:0]  a_bt;
    logic [7:0]  b_bt;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model of the registered channel state.
  logic [31:0] m_a_rd, m_b_rd;
  logic [7:0]  m_a_bt, m_b_bt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_a_rd = '0; m_b_rd = '0; m_a_bt = '0; m_b_bt = '0;
    exp_q.delete();
  endtask

  task automatic push(input logic [3:0] flags);
    exp_t e;
    e.flags = flags;
    e.a_rd  = m_a_rd;
    e.b_rd  = m_b_rd;
    e.a_bt  = m_a_bt;
    e.b_bt  = m_b_bt;
    e.cyc   = cyc + 1;
    exp_q.push_back(e);
  endtask

  // Expect a successful beat for ch completing on the next edge.
  task automatic exp_ok(input logic ch, input logic [31:0] d);
    if (ch == CH_A) begin
      m_a_rd = d; m_a_bt = m_a_bt + 8'd1; push(4'b1000);
    end else begin
      m_b_rd = d; m_b_bt = m_b_bt + 8'd1; push(4'b0100);
    end
  endtask

  task automatic exp_err(input logic ch);
    push((ch == CH_A) ? 4'b0010 : 4'b0001);
  endtask

  // One bus cycle: apply inputs, wait for the edge, settle 1ns.
  task automatic drive(input logic av, input logic sel, input logic hr,
                       input logic [31:0] d, input logic rsp);
    addr_valid = av; addr_sel = sel; HREADY = hr; HRDATA = d; HRESP = rsp;
    @(posedge HCLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_rdata"}, 64'(ch_a_rdata), 64'd0);
    check({tag, "_b_rdata"}, 64'(ch_b_rdata), 64'd0);
    check({tag, "_a_valid"}, 64'(ch_a_valid), 64'd0);
    check({tag, "_b_valid"}, 64'(ch_b_valid), 64'd0);
    check({tag, "_a_err"},   64'(ch_a_err),   64'd0);
    check({tag, "_b_err"},   64'(ch_b_err),   64'd0);
    check({tag, "_a_beats"}, 64'(ch_a_beats), 64'd0);
    check({tag, "_b_beats"}, 64'(ch_b_beats), 64'd0);
    check({tag, "_busy"},    64'(busy),       64'd0);
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    addr_valid = 1'b0; addr_sel = 1'b0; HREADY = 1'b1; HRDATA = '0; HRESP = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    check_all_zero("reset");
    model_clear();
    HRESETn = 1'b1;
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge HCLK) begin
    if (HRESETn && (ch_a_valid || ch_b_valid || ch_a_err || ch_b_err)) begin
      check("valid_exclusive", 64'(ch_a_valid & ch_b_valid), 64'd0);
      if (exp_q.size() == 0) begin
        check("spurious_pulse", 64'({ch_a_valid, ch_b_valid, ch_a_err, ch_b_err}), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_cycle", 64'(cyc), 64'(e.cyc));
        check("pulse_flags", 64'({ch_a_valid, ch_b_valid, ch_a_err, ch_b_err}), 64'(e.flags));
        check("a_rdata", 64'(ch_a_rdata), 64'(e.a_rd));
        check("b_rdata", 64'(ch_b_rdata), 64'(e.b_rd));
        check("a_beats", 64'(ch_a_beats), 64'(e.a_bt));
        check("b_beats", 64'(ch_b_beats), 64'(e.b_bt));
      end
    end
  end

  initial begin
    do_reset();

    // Single channel-A beat.
    drive(1'b1, CH_A, 1'b1, 32'h0, 1'b0);
    check("single_busy", 64'(busy), 64'd1);
    exp_ok(CH_A, 32'hDEADBEEF);
    drive(1'b0, CH_B, 1'b1, 32'hDEADBEEF, 1'b0);
    drive(1'b0, CH_B, 1'b1, 32'h0, 1'b0);
    check("single_idle", 64'(busy), 64'd0);

    // Back-to-back A then B.
    drive(1'b1, CH_A, 1'b1, 32'h0, 1'b0);
    check("b2b_busy0", 64'(busy), 64'd1);
    exp_ok(CH_A, 32'h11);
    drive(1'b1, CH_B, 1'b1, 32'h11, 1'b0);
    check("b2b_busy1", 64'(busy), 64'd1);
    exp_ok(CH_B, 32'h22);
    drive(1'b0, CH_A, 1'b1, 32'h22, 1'b0);
    drive(1'b0, CH_A, 1'b1, 32'h0, 1'b0);

    // Channel-B beat with 3 wait states; address inputs wiggle meanwhile.
    drive(1'b1, CH_B, 1'b1, 32'h0, 1'b0);
    drive(1'b1, CH_A, 1'b0, 32'h55, 1'b0);
    drive(1'b1, CH_B, 1'b0, 32'h55, 1'b0);
    drive(1'b1, CH_A, 1'b0, 32'h55, 1'b0);
    check("wait_busy", 64'(busy), 64'd1);
    exp_ok(CH_B, 32'h55);
    drive(1'b0, CH_A, 1'b1, 32'h55, 1'b0);
    drive(1'b0, CH_A, 1'b1, 32'h0, 1'b0);
    check("wait_idle", 64'(busy), 64'd0);

    // Channel-A beat with a two-cycle ERROR response.
    drive(1'b1, CH_A, 1'b1, 32'h0, 1'b0);
    drive(1'b0, CH_B, 1'b0, 32'h99, 1'b1);
`ifdef DMA_RESP_DEMUX_ERR_EN
    exp_err(CH_A);
`else
    exp_ok(CH_A, 32'h99);
`endif
    drive(1'b0, CH_B, 1'b1, 32'h99, 1'b1);
    drive(1'b0, CH_B, 1'b1, 32'h0, 1'b0);
    check("err_idle", 64'(busy), 64'd0);

    // 256 back-to-back A beats from a fresh reset: counter wraps to 0.
    do_reset();
    drive(1'b1, CH_A, 1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      exp_ok(CH_A, 32'h100 + 32'(i));
      drive((i < 255), CH_A, 1'b1, 32'h100 + 32'(i), 1'b0);
    end
    drive(1'b0, CH_A, 1'b1, 32'h0, 1'b0);
    check("wrap_a_beats", 64'(ch_a_beats), 64'd0);
    check("wrap_b_beats", 64'(ch_b_beats), 64'd0);

    // Reset during a DATA wait state.
    drive(1'b1, CH_A, 1'b1, 32'h0, 1'b0);
    drive(1'b0, CH_A, 1'b0, 32'h5A, 1'b0);
    check("pre_rst_busy", 64'(busy), 64'd1);
    #2;
    HRESETn = 1'b0;
    #1;
    check_all_zero("midbeat_rst");
    model_clear();
    addr_valid = 1'b0; HREADY = 1'b1;
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    repeat (3) drive(1'b0, CH_A, 1'b1, 32'h5A, 1'b0);
    check("post_rst_busy", 64'(busy), 64'd0);

    // Normal traffic after the release.
    drive(1'b1, CH_B, 1'b1, 32'h0, 1'b0);
    exp_ok(CH_B, 32'h77);
    drive(1'b0, CH_A, 1'b1, 32'h77, 1'b0);
    repeat (3) drive(1'b0, CH_A, 1'b1, 32'h0, 1'b0);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
